// File: rtl/ixc_gfifo_collect.sv
// rtl/ixc_gfifo_collect.sv - GFIFO record collector: FIFO plus header/payload beat serializer
// Optional stats counters: define IXC_GFIFO_COLLECT_STATS_EN
module ixc_gfifo_collect #(
    parameter int DEPTH = 4
) (
    input  logic                     fclk,
    input  logic                     frst_n,
    input  logic                     GFtsReq,
    input  logic [19:0]              GFcbid,
    input  logic [11:0]              GFlen,
    input  logic [511:0]             GFidata,
    output logic                     GFfull,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic                     out_last,
    output logic                     err_ovf,
    output logic                     err_len,
    output logic [$clog2(DEPTH):0]   level
`ifdef IXC_GFIFO_COLLECT_STATS_EN
    ,
    output logic [31:0]              stat_rec,
    output logic [15:0]              stat_drop
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [19:0]   mem_cbid [DEPTH];
    logic [11:0]   mem_len  [DEPTH];
    logic [511:0]  mem_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    state_t        state;
    state_t        state_nxt;
    logic [2:0]    k;
    logic [2:0]    k_nxt;

    logic [19:0]   head_cbid;
    logic [11:0]   head_len;
    logic [511:0]  head_data;
    logic [12:0]   len_up;
    logic [6:0]    nb_raw;
    logic [3:0]    nb;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          more;
    logic          full_nxt;

    assign level     = level_q;
    assign head_cbid = mem_cbid[rd_ptr];
    assign head_len  = mem_len[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Beat count: ceil(len/64) clamped to the 8 beats a 512-bit payload can fill
    assign len_up = {1'b0, head_len} + 13'd63;
    assign nb_raw = len_up[12:6];
    assign nb     = (nb_raw > 7'd8) ? 4'd8 : nb_raw[3:0];

    // A record remains after a pop if more were queued or one is arriving this cycle
    assign more = (level_q > LW'(1)) || GFtsReq;

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_data  = 64'h0;
        out_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level_q != '0 || GFtsReq) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = {20'h0, head_len, 12'h0, head_cbid};
                out_last  = (nb == 4'd0);
                if (out_ready) begin
                    k_nxt = 3'd0;
                    if (nb == 4'd0) begin
                        pop       = 1'b1;
                        state_nxt = more ? ST_HDR : ST_IDLE;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                out_valid = 1'b1;
                out_data  = head_data[{k, 6'd0} +: 64];
                out_last  = ({1'b0, k} == nb - 4'd1);
                if (out_ready) begin
                    if (out_last) begin
                        pop       = 1'b1;
                        k_nxt     = 3'd0;
                        state_nxt = more ? ST_HDR : ST_IDLE;
                    end else begin
                        k_nxt = k + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO still takes the push
        push_ok   = GFtsReq && ((level_q != DEPTH_L) || pop);
        drop      = GFtsReq && !push_ok;
        level_nxt = level_q + LW'(push_ok) - LW'(pop);
        full_nxt  = (level_nxt >= DEPTH_L - LW'(1));
    end

    always_ff @(posedge fclk) begin
        if (push_ok) begin
            mem_cbid[wr_ptr] <= GFcbid;
            mem_len[wr_ptr]  <= GFlen;
            mem_data[wr_ptr] <= GFidata;
        end
    end

    always_ff @(posedge fclk) begin
        if (!frst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            state   <= ST_IDLE;
            k       <= 3'd0;
            GFfull  <= 1'b0;
            err_ovf <= 1'b0;
            err_len <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q <= level_nxt;
            state   <= state_nxt;
            k       <= k_nxt;
            GFfull  <= full_nxt;
            if (drop) begin
                err_ovf <= 1'b1;
            end
            if (push_ok && (GFlen > 12'd512)) begin
                err_len <= 1'b1;
            end
        end
    end

`ifdef IXC_GFIFO_COLLECT_STATS_EN
    always_ff @(posedge fclk) begin
        if (!frst_n) begin
            stat_rec  <= 32'h0;
            stat_drop <= 16'h0;
        end else begin
            if (out_valid && out_ready && out_last && (stat_rec != 32'hFFFF_FFFF)) begin
                stat_rec <= stat_rec + 32'd1;
            end
            if (drop && (stat_drop != 16'hFFFF)) begin
                stat_drop <= stat_drop + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ixc_gfifo_collect.sv
// tb/tb_ixc_gfifo_collect.sv - scoreboard bench for ixc_gfifo_collect
module tb_ixc_gfifo_collect;

    localparam int DEPTH = 4;

    logic          fclk = 1'b0;
    logic          frst_n = 1'b0;
    logic          GFtsReq = 1'b0;
    logic [19:0]   GFcbid = '0;
    logic [11:0]   GFlen = '0;
    logic [511:0]  GFidata = '0;
    logic          GFfull;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_data;
    logic          out_last;
    logic          err_ovf;
    logic          err_len;
    logic [$clog2(DEPTH):0] level;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_data [$];
    logic        exp_last [$];
    int          mlevel = 0;
    bit          m_full = 0;
    bit          m_ovf = 0;
    bit          m_len = 0;
    bit          armed = 0;

    ixc_gfifo_collect #(.DEPTH(DEPTH)) dut (
        .fclk(fclk), .frst_n(frst_n),
        .GFtsReq(GFtsReq), .GFcbid(GFcbid), .GFlen(GFlen), .GFidata(GFidata),
        .GFfull(GFfull),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .err_ovf(err_ovf), .err_len(err_len), .level(level)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_rec(input logic [19:0] c, input logic [11:0] l, input logic [511:0] d);
        int n;
        n = (int'(l) + 63) / 64;
        if (n > 8) n = 8;
        exp_data.push_back({20'h0, l, 12'h0, c});
        exp_last.push_back(n == 0);
        for (int b = 0; b < n; b++) begin
            exp_data.push_back(d[b*64 +: 64]);
            exp_last.push_back(b == n - 1);
        end
    endtask

    // Sample 1ns before each rising edge; inputs change on the falling edge
    always begin
        logic        popped;
        logic [63:0] d;
        logic        l;
        @(negedge fclk);
        #4;
        if (!frst_n) begin
            exp_data.delete();
            exp_last.delete();
            mlevel = 0;
            m_full = 0;
            m_ovf  = 0;
            m_len  = 0;
            armed  = 1;
        end else if (armed) begin
            chk("level", 64'(level), 64'(mlevel));
            chk("gffull", 64'(GFfull), 64'(m_full));
            chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
            chk("err_len", 64'(err_len), 64'(m_len));
            chk("out_valid", 64'(out_valid), 64'(mlevel != 0));
            popped = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    chk("beat_unexpected", 64'(1), 64'(0));
                end else begin
                    d = exp_data.pop_front();
                    l = exp_last.pop_front();
                    chk("beat_data", out_data, d);
                    chk("beat_last", 64'(out_last), 64'(l));
                    popped = l;
                end
            end
            if (GFtsReq) begin
                if (mlevel < DEPTH || popped) begin
                    push_rec(GFcbid, GFlen, GFidata);
                    if (GFlen > 12'd512) m_len = 1;
                    mlevel++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (popped) mlevel--;
            m_full = (mlevel >= DEPTH - 1);
        end
    end

    task automatic cyc(input bit req, input bit rdy, input logic [19:0] c, input logic [11:0] l);
        @(negedge fclk);
        GFtsReq   = req;
        out_ready = rdy;
        GFcbid    = c;
        GFlen     = l;
        GFidata   = rnd512();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, rdy, 20'h0, 12'h0);
    endtask

    task automatic do_reset();
        @(negedge fclk);
        frst_n    = 1'b0;
        GFtsReq   = 1'b0;
        out_ready = 1'b0;
        @(negedge fclk);
        @(negedge fclk);
        frst_n = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((mlevel != 0 || exp_data.size() != 0) && t < 300) begin
            cyc(1'b0, 1'b1, 20'h0, 12'h0);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 64'(1), 64'(0));
        idle(2, 1'b1);
    endtask

    initial begin
        // Reset values
        frst_n = 1'b0;
        idle(3, 1'b0);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_gffull", 64'(GFfull), 64'(0));
        chk("rst_err_ovf", 64'(err_ovf), 64'(0));
        chk("rst_err_len", 64'(err_len), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        frst_n = 1'b1;

        // Single record, zero-length record, over-length record
        cyc(1'b1, 1'b1, 20'h12345, 12'd100);
        idle(5, 1'b1);
        cyc(1'b1, 1'b1, 20'h00005, 12'd0);
        idle(3, 1'b1);
        cyc(1'b1, 1'b1, 20'hABCDE, 12'd600);
        drain();
        chk("len_err_sticky", 64'(err_len), 64'(1));

        // Overflow with sink stalled
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 20'(i + 16), 12'd130);
        cyc(1'b0, 1'b0, 20'h0, 12'h0);
        #2;
        chk("ovf_err_ovf", 64'(err_ovf), 64'(1));
        chk("ovf_level", 64'(level), 64'(4));
        chk("ovf_gffull", 64'(GFfull), 64'(1));
        drain();

        // Full FIFO: push coincides with a single-beat pop
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 20'(i + 32), 12'd0);
        cyc(1'b1, 1'b1, 20'h000AA, 12'd0);
        cyc(1'b0, 1'b0, 20'h0, 12'h0);
        #2;
        chk("full_pushpop_level", 64'(level), 64'(4));
        chk("full_pushpop_ovf", 64'(err_ovf), 64'(0));
        drain();

        // Reset in the middle of a payload with three records queued
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 20'(i + 48), 12'd200);
        idle(1, 1'b0);
        idle(2, 1'b1);
        @(negedge fclk);
        frst_n = 1'b0;
        @(negedge fclk);
        frst_n    = 1'b1;
        out_ready = 1'b0;
        #2;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_level", 64'(level), 64'(0));
        cyc(1'b1, 1'b1, 20'h0BEEF, 12'd64);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 150; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                20'($urandom), 12'($urandom_range(0, 700)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
